// File: rtl/rf_write_queue.sv
`default_nettype none
// ============================================================================
// Module   : rf_write_queue
// Brief    : In-order writeback queue merging load/ALU results onto the
//            register-file write port, with read-port forwarding of pending data.
// Revision : 1.0 - initial release
// ============================================================================
module rf_write_queue #(
    parameter int DEPTH = 4,
    parameter int AW    = 5,
    parameter int DW    = 32
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       ld_valid,
    input  logic [AW-1:0]              ld_rd,
    input  logic [DW-1:0]              ld_data,
    output logic                       ld_ready,
    input  logic                       alu_valid,
    input  logic [AW-1:0]              alu_rd,
    input  logic [DW-1:0]              alu_data,
    output logic                       alu_ready,
    output logic                       regwen,
    output logic [AW-1:0]              addr_d,
    output logic [DW-1:0]              data_d,
    input  logic [AW-1:0]              addr_a,
    input  logic [AW-1:0]              addr_b,
    output logic                       fwd_a_hit,
    output logic                       fwd_b_hit,
    output logic [DW-1:0]              fwd_a_data,
    output logic [DW-1:0]              fwd_b_data,
    output logic [$clog2(DEPTH):0]     count
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    logic [AW-1:0] r_rd   [DEPTH];
    logic [DW-1:0] r_data [DEPTH];
    logic [PW-1:0] r_head;
    logic [PW-1:0] r_tail;
    logic [CW-1:0] r_count;
    logic          r_regwen;
    logic [AW-1:0] r_addr_d;
    logic [DW-1:0] r_data_d;

    logic [CW-1:0] w_free;
    logic [CW-1:0] w_alu_need;
    logic          w_ld_enq;
    logic          w_alu_enq;
    logic          w_pop;
    logic [1:0]    w_enq_cnt;
    logic [PW-1:0] w_alu_slot;

    // Space is judged from the registered count only; a pop this edge frees
    // its slot for acceptance next cycle.
    assign w_free     = CW'(DEPTH) - r_count;
    assign w_alu_need = CW'(1) + CW'(ld_valid && (ld_rd != '0));
    assign ld_ready   = !rst && (w_free >= CW'(1));
    assign alu_ready  = !rst && (w_free >= w_alu_need);

    assign w_ld_enq   = ld_valid  && ld_ready  && (ld_rd  != '0);
    assign w_alu_enq  = alu_valid && alu_ready && (alu_rd != '0);
    assign w_enq_cnt  = {1'b0, w_ld_enq} + {1'b0, w_alu_enq};
    assign w_alu_slot = r_tail + PW'(w_ld_enq);
    assign w_pop      = (r_count != '0);

    always_ff @(posedge clk) begin
        if (w_ld_enq) begin
            r_rd[r_tail]   <= ld_rd;
            r_data[r_tail] <= ld_data;
        end
        if (w_alu_enq) begin
            r_rd[w_alu_slot]   <= alu_rd;
            r_data[w_alu_slot] <= alu_data;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_head   <= '0;
            r_tail   <= '0;
            r_count  <= '0;
            r_regwen <= 1'b0;
            r_addr_d <= '0;
            r_data_d <= '0;
        end else begin
            r_tail   <= r_tail + PW'(w_enq_cnt);
            r_head   <= r_head + PW'(w_pop);
            r_count  <= r_count + CW'(w_enq_cnt) - CW'(w_pop);
            r_regwen <= w_pop;
            if (w_pop) begin
                r_addr_d <= r_rd[r_head];
                r_data_d <= r_data[r_head];
            end
        end
    end

    // Output register is the oldest candidate; queue entries are scanned
    // oldest to youngest so later matches override and the youngest wins.
    always_comb begin
        fwd_a_hit  = r_regwen && (r_addr_d == addr_a);
        fwd_a_data = fwd_a_hit ? r_data_d : '0;
        fwd_b_hit  = r_regwen && (r_addr_d == addr_b);
        fwd_b_data = fwd_b_hit ? r_data_d : '0;
        for (int i = 0; i < DEPTH; i++) begin
            if ((CW'(i) < r_count) && (r_rd[r_head + PW'(i)] == addr_a)) begin
                fwd_a_hit  = 1'b1;
                fwd_a_data = r_data[r_head + PW'(i)];
            end
            if ((CW'(i) < r_count) && (r_rd[r_head + PW'(i)] == addr_b)) begin
                fwd_b_hit  = 1'b1;
                fwd_b_data = r_data[r_head + PW'(i)];
            end
        end
        if (addr_a == '0) begin
            fwd_a_hit  = 1'b0;
            fwd_a_data = '0;
        end
        if (addr_b == '0) begin
            fwd_b_hit  = 1'b0;
            fwd_b_data = '0;
        end
    end

    assign regwen = r_regwen;
    assign addr_d = r_addr_d;
    assign data_d = r_data_d;
    assign count  = r_count;

endmodule
`default_nettype wire

// File: tb/tb_rf_write_queue.sv
`default_nettype none
// ============================================================================
// Module   : tb_rf_write_queue
// Brief    : Directed self-checking bench for rf_write_queue (DEPTH=4).
// Revision : 1.0 - initial release
// ============================================================================
module tb_rf_write_queue;

    localparam int DEPTH = 4;
    localparam int AW    = 5;
    localparam int DW    = 32;

    logic          clk = 1'b0;
    logic          rst;
    logic          ld_valid, alu_valid;
    logic [AW-1:0] ld_rd, alu_rd, addr_a, addr_b;
    logic [DW-1:0] ld_data, alu_data;
    logic          ld_ready, alu_ready, regwen;
    logic [AW-1:0] addr_d;
    logic [DW-1:0] data_d;
    logic          fwd_a_hit, fwd_b_hit;
    logic [DW-1:0] fwd_a_data, fwd_b_data;
    logic [2:0]    count;

    int n_checks = 0;
    int n_errors = 0;

    logic [AW+DW-1:0] sb[$];
    logic [AW+DW-1:0] exp_w;
    logic             exp_pop;

    rf_write_queue #(.DEPTH(DEPTH), .AW(AW), .DW(DW)) u_dut (
        .clk        (clk),
        .rst        (rst),
        .ld_valid   (ld_valid),
        .ld_rd      (ld_rd),
        .ld_data    (ld_data),
        .ld_ready   (ld_ready),
        .alu_valid  (alu_valid),
        .alu_rd     (alu_rd),
        .alu_data   (alu_data),
        .alu_ready  (alu_ready),
        .regwen     (regwen),
        .addr_d     (addr_d),
        .data_d     (data_d),
        .addr_a     (addr_a),
        .addr_b     (addr_b),
        .fwd_a_hit  (fwd_a_hit),
        .fwd_b_hit  (fwd_b_hit),
        .fwd_a_data (fwd_a_data),
        .fwd_b_data (fwd_b_data),
        .count      (count)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst = 1'b1;
        ld_valid = 1'b1; ld_rd = 5'd3; ld_data = 32'h1;
        alu_valid = 1'b1; alu_rd = 5'd4; alu_data = 32'h2;
        addr_a = '0; addr_b = '0;

        // Reset with both producers requesting
        #1;
        check("rst_ld_ready", ld_ready, 0);
        check("rst_alu_ready", alu_ready, 0);
        tick();
        check("rst_ld_ready2", ld_ready, 0);
        check("rst_alu_ready2", alu_ready, 0);
        tick();
        rst = 1'b0; ld_valid = 1'b0; alu_valid = 1'b0;
        #1;
        check("rst_regwen", regwen, 0);
        check("rst_addr_d", addr_d, 0);
        check("rst_data_d", data_d, 0);
        check("rst_count", count, 0);

        // Single write, 1-cycle latency
        alu_valid = 1'b1; alu_rd = 5'd5; alu_data = 32'h12345678;
        #1;
        check("single_alu_ready", alu_ready, 1);
        tick();
        alu_valid = 1'b0; addr_a = 5'd5;
        #1;
        check("single_count", count, 1);
        check("single_regwen_n", regwen, 0);
        check("single_fwd_hit", fwd_a_hit, 1);
        check("single_fwd_data", fwd_a_data, 32'h12345678);
        tick();
        check("single_regwen", regwen, 1);
        check("single_addr_d", addr_d, 5);
        check("single_data_d", data_d, 32'h12345678);
        check("single_count_pop", count, 0);
        check("single_fwd_outreg", fwd_a_data, 32'h12345678);
        tick();
        check("single_regwen_off", regwen, 0);
        check("single_addr_hold", addr_d, 5);
        check("single_fwd_gone", fwd_a_hit, 0);

        // Dual enqueue to the same rd
        ld_valid = 1'b1; ld_rd = 5'd7; ld_data = 32'hAAAA0000;
        alu_valid = 1'b1; alu_rd = 5'd7; alu_data = 32'hBBBB0000;
        addr_a = 5'd7;
        #1;
        check("dual_ld_ready", ld_ready, 1);
        check("dual_alu_ready", alu_ready, 1);
        tick();
        ld_valid = 1'b0; alu_valid = 1'b0;
        #1;
        check("dual_count", count, 2);
        check("dual_fwd_hit0", fwd_a_hit, 1);
        check("dual_fwd_data0", fwd_a_data, 32'hBBBB0000);
        tick();
        check("dual_regwen1", regwen, 1);
        check("dual_data1", data_d, 32'hAAAA0000);
        check("dual_fwd_data1", fwd_a_data, 32'hBBBB0000);
        tick();
        check("dual_regwen2", regwen, 1);
        check("dual_data2", data_d, 32'hBBBB0000);
        check("dual_fwd_hit2", fwd_a_hit, 1);
        check("dual_fwd_data2", fwd_a_data, 32'hBBBB0000);
        tick();
        check("dual_regwen_off", regwen, 0);
        check("dual_fwd_gone", fwd_a_hit, 0);

        // Writes to x0 handshake but are dropped
        ld_valid = 1'b1; ld_rd = 5'd0; ld_data = 32'h55;
        addr_a = 5'd0;
        #1;
        check("x0_ld_ready", ld_ready, 1);
        tick();
        ld_valid = 1'b0;
        #1;
        check("x0_count", count, 0);
        check("x0_regwen", regwen, 0);
        check("x0_fwd_hit", fwd_a_hit, 0);
        tick();
        check("x0_regwen2", regwen, 0);

        // Both producers held valid: backpressure and in-order retire
        sb.delete();
        for (int c = 0; c < 10; c++) begin
            ld_valid = 1'b1; ld_rd = 5'(2 * c + 1); ld_data = 32'h1000_0000 + 32'(2 * c);
            alu_valid = 1'b1; alu_rd = 5'(2 * c + 2); alu_data = 32'h1000_0001 + 32'(2 * c);
            #1;
            check("bp_ld_ready", ld_ready, (DEPTH - sb.size()) >= 1);
            check("bp_alu_ready", alu_ready, (DEPTH - sb.size()) >= 2);
            exp_pop = (sb.size() > 0);
            if (exp_pop) exp_w = sb.pop_front();
            if ((DEPTH - sb.size() - (exp_pop ? 1 : 0)) >= 1) sb.push_back({ld_rd, ld_data});
            if ((DEPTH - sb.size() - (exp_pop ? 1 : 0)) >= 1 && (DEPTH - (sb.size() - 1) - (exp_pop ? 1 : 0)) >= 2)
                sb.push_back({alu_rd, alu_data});
            tick();
            check("bp_regwen", regwen, exp_pop);
            if (exp_pop) begin
                check("bp_addr_d", addr_d, exp_w[AW+DW-1:DW]);
                check("bp_data_d", data_d, exp_w[DW-1:0]);
            end
            check("bp_count", count, sb.size());
            check("bp_count_max", count <= 3'(DEPTH), 1);
        end
        ld_valid = 1'b0; alu_valid = 1'b0;
        for (int d = 0; d < 8; d++) begin
            if (sb.size() == 0) break;
            exp_w = sb.pop_front();
            tick();
            check("drain_regwen", regwen, 1);
            check("drain_addr_d", addr_d, exp_w[AW+DW-1:DW]);
            check("drain_data_d", data_d, exp_w[DW-1:0]);
        end
        check("drain_count", count, 0);
        tick();
        check("drain_regwen_off", regwen, 0);

        // Reset with three entries queued
        ld_valid = 1'b1; ld_rd = 5'd10; ld_data = 32'hC0DE000A;
        alu_valid = 1'b1; alu_rd = 5'd11; alu_data = 32'hC0DE000B;
        tick();
        ld_rd = 5'd12; ld_data = 32'hC0DE000C;
        alu_rd = 5'd13; alu_data = 32'hC0DE000D;
        tick();
        ld_valid = 1'b0; alu_valid = 1'b0;
        addr_a = 5'd11; addr_b = 5'd13;
        #1;
        check("mid_count_pre", count, 3);
        check("mid_fwd_b_pre", fwd_b_data, 32'hC0DE000D);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        #1;
        check("mid_count", count, 0);
        check("mid_regwen", regwen, 0);
        check("mid_addr_d", addr_d, 0);
        check("mid_fwd_a", fwd_a_hit, 0);
        check("mid_fwd_b", fwd_b_hit, 0);
        tick();
        check("mid_regwen2", regwen, 0);
        tick();
        check("mid_regwen3", regwen, 0);
        check("mid_count3", count, 0);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
